act_mac_quant: RTL and testbench
================================

Name: act_mac_quant

Overview:
Downstream consumer of the input activation controller's byte stream. Multiplies each signed 8-bit activation by a time-aligned signed 8-bit weight and accumulates NUM_MACS products onto a bias. It then requantizes the sum (rounding shift, optional ReLU, saturation) to one 8-bit output activation. It is one lane of the conv/MLP datapath and is armed per output element by the layer sequencer.

Parameters:
ACT_WIDTH, 8, activation width, signed two's complement
WGT_WIDTH, 8, weight width, signed
ACC_WIDTH, 32, accumulator/bias width, signed
LEN_WIDTH, 16, width of NUM_MACS
OUT_WIDTH, 8, output activation width, signed

Ports:
CLK  in  1  clock; all logic on rising edge
RESETN  in  1  synchronous active-low reset, sampled on rising edge of CLK
START  in  1  arm one output computation; accepted only in IDLE
NUM_MACS  in  LEN_WIDTH  products per output; latched on accepted START
BIAS  in  ACC_WIDTH  signed accumulator preload; latched on accepted START
SHIFT  in  5  arithmetic right shift for requant; latched on accepted START
RELU_EN  in  1  clamp negative results to 0; latched on accepted START
IN_ACT_DATA  in  ACT_WIDTH  activation byte, connects to upstream IN_ACT_DATA_OUT
IN_ACT_VALID  in  1  activation valid, connects to upstream DATA_VALID (no backpressure)
WGT_DATA  in  WGT_WIDTH  weight byte, must be cycle-aligned with activation
WGT_VALID  in  1  weight valid
OUT_DATA  out  OUT_WIDTH  requantized result, held until next result
OUT_VALID  out  1  one-cycle pulse when OUT_DATA updates
ACC_OUT  out  ACC_WIDTH  raw final accumulator (bias + products), updated with OUT_DATA
BUSY  out  1  high whenever state != IDLE
ERR  out  1  sticky protocol error

Behaviour:
- Reset (RESETN=0 at an edge): state IDLE; accumulator, count, product register, OUT_DATA, ACC_OUT, OUT_VALID, ERR all 0. BUSY=0. Reset mid-operation aborts the computation with no OUT_VALID.
- FSM states: IDLE, ACCUM, DRAIN, QUANT.
- IDLE: on START, latch config, acc<=sign-extended BIAS, count<=0, ERR<=0. Go to ACCUM, or to DRAIN if NUM_MACS==0.
- ACCUM: a beat is accepted when IN_ACT_VALID && WGT_VALID.
  - On an accepted beat: prod_q <= signed ACT*WGT (16-bit, sign-extended), prod_v<=1, count++.
  - Any cycle with prod_v=1: acc <= acc + prod_q (wraps mod 2^ACC_WIDTH, no saturation).
  - When the accepted beat makes count==NUM_MACS, go to DRAIN. Gaps (both valids low) are allowed indefinitely.
- DRAIN: add the last prod_q, prod_v<=0, go to QUANT.
- QUANT: compute r = acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0), then r >>>= SHIFT (arithmetic, in ACC_WIDTH+1 bits to avoid overflow on rounding add). If RELU_EN and r<0, r=0. Saturate to [-128,127]. Register OUT_DATA<=r, ACC_OUT<=acc, OUT_VALID<=1, go to IDLE.
- Latency: Nth beat presented in cycle c -> OUT_VALID high in cycle c+3 only. With NUM_MACS==0, START in cycle s -> OUT_VALID in cycle s+3.
- START while BUSY: ignored, no effect on config or ERR.
- ERR set (sticky until next accepted START or reset) when:
  - IN_ACT_VALID xor WGT_VALID in ACCUM; the beat is not accepted and not counted.
  - IN_ACT_VALID or WGT_VALID high in IDLE, DRAIN or QUANT; the data is dropped.
- START and a valid beat in the same IDLE cycle: the beat is dropped and ERR=1 (ERR set wins over START clear). Beats are counted from the next cycle.
- Back-to-back: START may be asserted in the cycle OUT_VALID is high; that is a legal IDLE cycle.

Test Plan:
1. START NUM_MACS=4, BIAS=0, SHIFT=0, RELU_EN=0; acts {1,2,3,4}, wgts {5,6,7,8} on consecutive cycles -> ACC_OUT=70, OUT_DATA=70, OUT_VALID exactly 1 cycle, 3 cycles after the 4th beat; ERR=0.
2. NUM_MACS=2, BIAS=10, SHIFT=2; acts {-3,100}, wgts {7,-2} with 3 idle cycles between beats -> ACC_OUT=-211, OUT_DATA=-53 (0xCB). Repeat with RELU_EN=1 -> OUT_DATA=0.
3. Saturation, NUM_MACS=2, SHIFT=0: acts {127,127}, wgts {127,127} -> ACC_OUT=32258, OUT_DATA=127. Acts {-128,-128}, wgts {127,127} -> ACC_OUT=-32512, OUT_DATA=-128.
4. NUM_MACS=3, acts {1,1,1}, wgts {2,2,2}, with one cycle of IN_ACT_VALID=1/WGT_VALID=0 (act=50) inserted -> ERR=1, OUT_DATA=6. Next START clears ERR.
5. NUM_MACS=0, BIAS=300, SHIFT=1 -> OUT_DATA=127 (150 saturated), ACC_OUT=300, OUT_VALID at START cycle+3. A START pulse while BUSY is ignored.
6. Reset asserted in ACCUM after 2 of 4 beats -> BUSY=0, OUT_VALID never pulses. Fresh START with case 1 stimulus -> OUT_DATA=70.

Source files
------------

// File: rtl/act_mac_quant.sv
// One conv/MLP lane: multiply-accumulate NUM_MACS activation*weight products onto a bias,
// then requantize (rounding shift, optional ReLU, saturation) to one output activation.
module act_mac_quant #(
  parameter int ACT_WIDTH = 8,
  parameter int WGT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic [LEN_WIDTH-1:0] NUM_MACS,
  input  logic [ACC_WIDTH-1:0] BIAS,
  input  logic [4:0]           SHIFT,
  input  logic                 RELU_EN,
  input  logic [ACT_WIDTH-1:0] IN_ACT_DATA,
  input  logic                 IN_ACT_VALID,
  input  logic [WGT_WIDTH-1:0] WGT_DATA,
  input  logic                 WGT_VALID,
  output logic [OUT_WIDTH-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  output logic [ACC_WIDTH-1:0] ACC_OUT,
  output logic                 BUSY,
  output logic                 ERR
);

  // state | meaning
  // IDLE  | waiting for START; any valid here is a protocol error
  // ACCUM | accepting aligned act/wgt beats, folding registered products into acc
  // DRAIN | folding the final registered product into acc
  // QUANT | requantizing acc and publishing OUT_DATA/ACC_OUT
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, QUANT} state_t;

  localparam int PROD_WIDTH = ACT_WIDTH + WGT_WIDTH;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]         count_q, count_d;
  logic [LEN_WIDTH-1:0]         num_macs_q, num_macs_d;
  logic signed [PROD_WIDTH-1:0] prod_q, prod_d;
  logic                         prod_v_q, prod_v_d;
  logic [4:0]                   shift_q, shift_d;
  logic                         relu_q, relu_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic [ACC_WIDTH-1:0]         acc_out_q, acc_out_d;
  logic                         out_valid_q, out_valid_d;
  logic                         err_q, err_d;

  logic                         beat;
  logic                         last_beat;
  logic signed [PROD_WIDTH-1:0] prod_calc;
  logic signed [ACC_WIDTH:0]    rnd, r_sum, r_shr, r_relu;
  logic [OUT_WIDTH-1:0]         q_sat;

  assign beat      = IN_ACT_VALID && WGT_VALID;
  assign last_beat = beat && ((count_q + LEN_WIDTH'(1)) == num_macs_q);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      num_macs_q  <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      num_macs_q  <= num_macs_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = (NUM_MACS == '0) ? DRAIN : ACCUM;
      ACCUM:   if (last_beat) state_d = DRAIN;
      DRAIN:   state_d = QUANT;
      QUANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding add is done one bit wider than acc so the round-half-up term cannot overflow.
  always_comb begin
    prod_calc = PROD_WIDTH'($signed(IN_ACT_DATA)) * PROD_WIDTH'($signed(WGT_DATA));
    rnd       = (shift_q == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift_q - 5'd1));
    r_sum     = $signed({acc_q[ACC_WIDTH-1], acc_q}) + rnd;
    r_shr     = r_sum >>> shift_q;
    r_relu    = (relu_q && (r_shr < 0)) ? '0 : r_shr;
    if (r_relu > (ACC_WIDTH+1)'(OUT_MAX))      q_sat = OUT_MAX;
    else if (r_relu < (ACC_WIDTH+1)'(OUT_MIN)) q_sat = OUT_MIN;
    else                                       q_sat = r_relu[OUT_WIDTH-1:0];
  end

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    num_macs_d  = num_macs_q;
    prod_d      = prod_q;
    prod_v_d    = prod_v_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    out_data_d  = out_data_q;
    acc_out_d   = acc_out_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          num_macs_d = NUM_MACS;
          acc_d      = BIAS;
          shift_d    = SHIFT;
          relu_d     = RELU_EN;
          count_d    = '0;
          prod_v_d   = 1'b0;
          err_d      = 1'b0;
        end
        // A stray beat in the START cycle still flags, overriding the clear.
        if (IN_ACT_VALID || WGT_VALID) err_d = 1'b1;
      end
      ACCUM: begin
        if (prod_v_q) acc_d = acc_q + ACC_WIDTH'(prod_q);
        prod_v_d = beat;
        if (beat) begin
          prod_d  = prod_calc;
          count_d = count_q + LEN_WIDTH'(1);
        end
        if (IN_ACT_VALID ^ WGT_VALID) err_d = 1'b1;
      end
      DRAIN: begin
        if (prod_v_q) acc_d = acc_q + ACC_WIDTH'(prod_q);
        prod_v_d = 1'b0;
        if (IN_ACT_VALID || WGT_VALID) err_d = 1'b1;
      end
      QUANT: begin
        out_data_d  = q_sat;
        acc_out_d   = acc_q;
        out_valid_d = 1'b1;
        if (IN_ACT_VALID || WGT_VALID) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    BUSY      = (state_q != IDLE);
    OUT_DATA  = out_data_q;
    OUT_VALID = out_valid_q;
    ACC_OUT   = acc_out_q;
    ERR       = err_q;
  end

endmodule

// File: tb/tb_act_mac_quant.sv
// Directed and randomized checks of act_mac_quant against an arithmetic reference of
// the MAC + rounding-shift/ReLU/saturation rules.
module tb_act_mac_quant;

  logic               clk = 1'b0;
  logic               resetn, start, relu_en;
  logic [15:0]        num_macs;
  logic [31:0]        bias;
  logic [4:0]         shift;
  logic signed [7:0]  in_act_data, wgt_data;
  logic               in_act_valid, wgt_valid;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic signed [31:0] acc_out;
  logic               busy, err;

  int errs   = 0;
  int checks = 0;
  int a[8];
  int w[8];

  always #5 clk = ~clk;

  act_mac_quant dut (
    .CLK(clk), .RESETN(resetn), .START(start), .NUM_MACS(num_macs), .BIAS(bias),
    .SHIFT(shift), .RELU_EN(relu_en), .IN_ACT_DATA(in_act_data), .IN_ACT_VALID(in_act_valid),
    .WGT_DATA(wgt_data), .WGT_VALID(wgt_valid), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .ACC_OUT(acc_out), .BUSY(busy), .ERR(err)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_acc(input int b, input int n);
    int s = b;
    for (int i = 0; i < n; i++) s += a[i] * w[i];
    return s;
  endfunction

  // Round half up, floor-divide by 2^sh, optional ReLU, clamp to int8.
  function automatic int ref_out(input int acc, input int sh, input bit relu);
    longint r = acc;
    longint d = longint'(1) << sh;
    longint q;
    if (sh > 0) r += d / 2;
    q = r / d;
    if ((r % d != 0) && (r < 0)) q -= 1;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic run_op(input int n, input int b, input int sh, input bit relu, input int gap,
                        input int bad_at, input bit start_beat,
                        input int exp_acc, input int exp_out, input bit exp_err);
    start = 1'b1; num_macs = n[15:0]; bias = b; shift = sh[4:0]; relu_en = relu;
    if (start_beat) begin
      in_act_valid = 1'b1; wgt_valid = 1'b1; in_act_data = 8'sd99; wgt_data = 8'sd99;
    end
    step();
    start = 1'b0; in_act_valid = 1'b0; wgt_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    if (start_beat) chk("err_start_beat", err, 1);
    else            chk("err_cleared_by_start", err, 0);
    for (int i = 0; i < n; i++) begin
      if (i == bad_at) begin
        in_act_valid = 1'b1; in_act_data = 8'sd50; wgt_data = 8'sd3;
        step();
        in_act_valid = 1'b0;
      end
      repeat (gap) step();
      in_act_data = a[i][7:0]; wgt_data = w[i][7:0];
      in_act_valid = 1'b1; wgt_valid = 1'b1;
      step();
      in_act_valid = 1'b0; wgt_valid = 1'b0;
    end
    chk("ov_early_1", out_valid, 0);
    step();
    chk("ov_early_2", out_valid, 0);
    step();
    chk("ov_pulse", out_valid, 1);
    chk("acc_out", acc_out, exp_acc);
    chk("out_data", out_data, exp_out);
    chk("err_end", err, exp_err);
    chk("busy_end", busy, 0);
    step();
    chk("ov_single", out_valid, 0);
    chk("out_hold", out_data, exp_out);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, n, b, sh, acc;
    bit relu;
    resetn = 1'b0; start = 1'b0; num_macs = '0; bias = '0; shift = '0; relu_en = 1'b0;
    in_act_data = '0; wgt_data = '0; in_act_valid = 1'b0; wgt_valid = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_out", out_data, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_err", err, 0);
    resetn = 1'b1;
    step();

    a[0:3] = '{1, 2, 3, 4}; w[0:3] = '{5, 6, 7, 8};
    run_op(4, 0, 0, 0, 0, -1, 0, 70, 70, 0);

    a[0:1] = '{-3, 100}; w[0:1] = '{7, -2};
    run_op(2, 10, 2, 0, 3, -1, 0, -211, -53, 0);
    run_op(2, 10, 2, 1, 3, -1, 0, -211, 0, 0);

    a[0:1] = '{127, 127}; w[0:1] = '{127, 127};
    run_op(2, 0, 0, 0, 0, -1, 0, 32258, 127, 0);
    a[0:1] = '{-128, -128};
    run_op(2, 0, 0, 0, 0, -1, 0, -32512, -128, 0);

    a[0:2] = '{1, 1, 1}; w[0:2] = '{2, 2, 2};
    run_op(3, 0, 0, 0, 0, 1, 0, 6, 6, 1);

    // NUM_MACS=0 with an ignored START while busy
    start = 1'b1; num_macs = 16'd0; bias = 300; shift = 5'd1; relu_en = 1'b0;
    step();
    chk("z_busy", busy, 1);
    chk("z_err_cleared", err, 0);
    num_macs = 16'd5; bias = 0; shift = 5'd0;
    step();
    start = 1'b0;
    chk("z_ov_early", out_valid, 0);
    step();
    chk("z_ov_pulse", out_valid, 1);
    chk("z_out", out_data, 127);
    chk("z_acc", acc_out, 300);
    chk("z_busy_end", busy, 0);
    step();
    chk("z_ov_single", out_valid, 0);

    // Reset mid-ACCUM aborts without a result
    start = 1'b1; num_macs = 16'd4; bias = 0; shift = 5'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_act_data = 8'sd1; wgt_data = 8'sd1; in_act_valid = 1'b1; wgt_valid = 1'b1;
      step();
    end
    in_act_valid = 1'b0; wgt_valid = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_out", out_data, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) pulses++;
      step();
    end
    chk("mid_rst_no_ov", pulses, 0);
    a[0:3] = '{1, 2, 3, 4}; w[0:3] = '{5, 6, 7, 8};
    run_op(4, 0, 0, 0, 0, -1, 0, 70, 70, 0);

    // Stray valid in IDLE, then a beat coinciding with START is dropped
    wgt_valid = 1'b1;
    step();
    wgt_valid = 1'b0;
    chk("idle_valid_err", err, 1);
    a[0] = 2; w[0] = 3;
    run_op(1, 0, 0, 0, 0, -1, 1, 6, 6, 1);

    for (int t = 0; t < 12; t++) begin
      n    = int'($urandom_range(1, 8));
      b    = (t % 3 == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
      sh   = int'($urandom_range(0, 20));
      relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        a[i] = int'($urandom_range(0, 255)) - 128;
        w[i] = int'($urandom_range(0, 255)) - 128;
      end
      acc = ref_acc(b, n);
      run_op(n, b, sh, relu, int'($urandom_range(0, 2)), -1, 0, acc, ref_out(acc, sh, relu), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
